// File: rtl/bit_destuffing_if.sv
// Sampler/decoder-facing bundle for the CAN receive bit destuffer.
// master = sampler side driving bus samples, slave = the destuffer itself.
interface bit_destuffing_if;
    logic       enable;
    logic       sample_point;
    logic       rx_bit;
    logic       destuff_active;
    logic       destuffed_bit;
    logic       destuffed_valid;
    logic       stuff_bit_removed;
    logic       stuff_error;
    logic [2:0] consecutive_count;

    modport master (
        output enable, sample_point, rx_bit, destuff_active,
        input  destuffed_bit, destuffed_valid, stuff_bit_removed, stuff_error, consecutive_count
    );

    modport slave (
        input  enable, sample_point, rx_bit, destuff_active,
        output destuffed_bit, destuffed_valid, stuff_bit_removed, stuff_error, consecutive_count
    );
endinterface

// File: rtl/bit_destuffing.sv
// CAN receive bit destuffer: drops the stuff bit after each run of STUFF_LIMIT equal bits.
// Define BIT_DESTUFF_ERR_EN to flag a too-long run as a stuff error (ERROR state).
module bit_destuffing #(
    parameter int unsigned STUFF_LIMIT = 5
) (
    input logic             clock,
    input logic             reset,
    bit_destuffing_if.slave bus
);
    localparam logic [2:0] LIMIT = 3'(STUFF_LIMIT);

`ifdef BIT_DESTUFF_ERR_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERROR} state_t;
    logic   r_error;
`else
    typedef enum logic {S_IDLE, S_RUN} state_t;
`endif

    state_t     r_state;
    logic       r_last;
    logic [2:0] r_count;
    logic       r_bit;
    logic       r_valid;
    logic       r_removed;
    logic       w_same;
    logic       w_at_limit;

    assign w_same     = (bus.rx_bit == r_last);
    assign w_at_limit = (r_count == LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_count   <= '0;
            r_bit     <= 1'b0;
            r_valid   <= 1'b0;
            r_removed <= 1'b0;
`ifdef BIT_DESTUFF_ERR_EN
            r_error   <= 1'b0;
`endif
        end else begin
            r_valid   <= 1'b0;
            r_removed <= 1'b0;
            if (!bus.enable) begin
                r_state <= S_IDLE;
                r_count <= '0;
                r_last  <= 1'b1;
`ifdef BIT_DESTUFF_ERR_EN
                r_error <= 1'b0;
`endif
            end else if (bus.sample_point) begin
                case (r_state)
                    S_IDLE: begin
                        r_valid <= 1'b1;
                        r_bit   <= bus.rx_bit;
                        if (bus.destuff_active) begin
                            r_state <= S_RUN;
                            r_count <= 3'd1;
                            r_last  <= bus.rx_bit;
                        end
                    end
                    S_RUN: begin
                        if (!bus.destuff_active) begin
                            r_state <= S_IDLE;
                            r_count <= '0;
                            r_last  <= 1'b1;
                            r_valid <= 1'b1;
                            r_bit   <= bus.rx_bit;
                        end else if (!w_at_limit) begin
                            r_valid <= 1'b1;
                            r_bit   <= bus.rx_bit;
                            if (w_same) begin
                                r_count <= r_count + 3'd1;
                            end else begin
                                r_count <= 3'd1;
                                r_last  <= bus.rx_bit;
                            end
`ifdef BIT_DESTUFF_ERR_EN
                        end else if (w_same) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
`endif
                        end else begin
                            // stuff bit is dropped but opens the next run
                            r_removed <= 1'b1;
                            r_count   <= 3'd1;
                            r_last    <= bus.rx_bit;
                        end
                    end
`ifdef BIT_DESTUFF_ERR_EN
                    S_ERROR: begin
                        if (!bus.destuff_active) begin
                            r_state <= S_IDLE;
                            r_count <= '0;
                            r_last  <= 1'b1;
                            r_error <= 1'b0;
                        end
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.destuffed_bit     = r_bit;
    assign bus.destuffed_valid   = r_valid;
    assign bus.stuff_bit_removed = r_removed;
    assign bus.consecutive_count = r_count;
`ifdef BIT_DESTUFF_ERR_EN
    assign bus.stuff_error       = r_error;
`else
    assign bus.stuff_error       = 1'b0;
`endif
endmodule
